// File: rtl/sia_tx.sv
// sia_tx: SIA transmit back end. A word FIFO feeds a raw LSB-first shifter; software supplies all framing bits.
// Latency: a push at edge N loads at N+1 when idle, and bit 0 drives txd_o after N+2. Each bit lasts rate+1 clocks.
// Backpressure: txq_not_full_o drops when the FIFO holds 2^DEPTH_LOG2 words. A push while full is silently dropped.
// Ports: clk_i/reset_i (async, active-low); txq_we_i/txq_dat_i push stream; txq_not_full_o/txq_empty_o/tx_idle_o status;
//        bits_i (frame length), bitrat_i (bit time - 1), txcmod_i ([2] clk enable, [1] clk idle level), eedd_i/eedc_i
//        drive enables; txd_o serial data (idle 1), txc_o serial clock.
module sia_tx #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        txq_we_i,
  input  logic [15:0] txq_dat_i,
  output logic        txq_not_full_o,
  output logic        txq_empty_o,
  output logic        tx_idle_o,
  input  logic [4:0]  bits_i,
  input  logic [19:0] bitrat_i,
  input  logic [2:0]  txcmod_i,
  input  logic        eedd_i,
  input  logic        eedc_i,
  output logic        txd_o,
  output logic        txc_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic [0:0]  state;
  logic [15:0] sr;
  logic [19:0] rate;
  logic [19:0] baud;
  logic [4:0]  remaining;

  logic       empty;
  logic       push;
  logic       last_bit;
  logic       load;
  logic [4:0] nbits;
  logic       clk_active;
  logic       cmod_unused;

  // txcmod_i[0] is reserved.
  assign cmod_unused = txcmod_i[0];

  assign empty = (count == '0);
  // count never exceeds DEPTH, so its MSB is set exactly when the FIFO is full.
  assign push  = txq_we_i & ~count[DEPTH_LOG2];

  assign last_bit = (state == ST_SHIFT) && (baud == '0) && (remaining == 5'd1);
  // Loading on the final cycle of the last bit makes frames run back-to-back with no gap.
  assign load     = ~empty & ((state == ST_IDLE) | last_bit);
  assign nbits    = (bits_i == 5'd0) ? 5'd1 : bits_i;

  assign txq_not_full_o = ~count[DEPTH_LOG2];
  assign txq_empty_o    = empty;
  assign tx_idle_o      = empty & (state == ST_IDLE);

  // Storage needs no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= txq_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Shifter: bits_i/bitrat_i are captured only at load, so mid-frame changes wait for the next frame.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= ST_IDLE;
      sr        <= '1;
      rate      <= '0;
      baud      <= '0;
      remaining <= '0;
    end else if (load) begin
      state     <= ST_SHIFT;
      sr        <= mem[rd_ptr];
      rate      <= bitrat_i;
      baud      <= bitrat_i;
      remaining <= nbits;
    end else if (state == ST_SHIFT) begin
      if (baud != '0) begin
        baud <= baud - 1'b1;
      end else if (remaining > 5'd1) begin
        // Fill with 1s so frames longer than 16 bits trail off at the line idle level.
        sr        <= {1'b1, sr[15:1]};
        baud      <= rate;
        remaining <= remaining - 1'b1;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // The clock is active in the second half of each bit. With single-clock bits there is no first half,
  // so the clock stays at its idle level rather than sitting permanently active.
  assign clk_active = (state == ST_SHIFT) & txcmod_i[2] & (rate != '0) & (baud <= (rate >> 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      txd_o <= 1'b1;
      txc_o <= 1'b0;
    end else begin
      txd_o <= (eedd_i && (state == ST_SHIFT)) ? sr[0] : 1'b1;
      txc_o <= (eedc_i && clk_active) ? ~txcmod_i[1] : txcmod_i[1];
    end
  end

endmodule

// File: tb/tb_sia_tx.sv
// tb_sia_tx: self-checking bench for sia_tx.
// Every accepted push schedules its expected per-clock txd/txc samples in a queue. A negedge monitor pops and compares them.
// Frame-level cases are driven from a table, followed by hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_sia_tx;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        txq_we_i;
  logic [15:0] txq_dat_i;
  logic        txq_not_full_o;
  logic        txq_empty_o;
  logic        tx_idle_o;
  logic [4:0]  bits_i;
  logic [19:0] bitrat_i;
  logic [2:0]  txcmod_i;
  logic        eedd_i;
  logic        eedc_i;
  logic        txd_o;
  logic        txc_o;

  sia_tx #(.DEPTH_LOG2(2)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .txq_we_i       (txq_we_i),
    .txq_dat_i      (txq_dat_i),
    .txq_not_full_o (txq_not_full_o),
    .txq_empty_o    (txq_empty_o),
    .tx_idle_o      (tx_idle_o),
    .bits_i         (bits_i),
    .bitrat_i       (bitrat_i),
    .txcmod_i       (txcmod_i),
    .eedd_i         (eedd_i),
    .eedc_i         (eedc_i),
    .txd_o          (txd_o),
    .txc_o          (txc_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per clock of line output.
  typedef struct {
    int   cyc;
    logic b;
    int   ph;
    int   rate;
  } samp_t;

  samp_t exp_q[$];
  int    load_q[$];   // predicted load edge of each accepted word
  int    prev_end = 0; // first edge after which the scheduled stream is done
  bit    mon_en = 1'b0;

  // Drive-side values as sampled by the DUT at the coming edge.
  logic       eedd_s = 1'b1;
  logic       eedc_s = 1'b1;
  logic [2:0] cmod_s = 3'b000;

  always @(negedge clk_i) begin : monitor
    samp_t e;
    bit    have;
    logic  ed;
    logic  ec;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_stale: sample for edge %0d was skipped (now %0d)", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      have = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (have) e = exp_q.pop_front();
      ed = (have && eedd_s) ? e.b : 1'b1;
      ec = cmod_s[1];
      if (have && cmod_s[2] && eedc_s && e.rate != 0 && (e.rate - e.ph) <= (e.rate >> 1))
        ec = ~cmod_s[1];
      chk("txd", txd_o, ed);
      chk("txc", txc_o, ec);
    end
    eedd_s = eedd_i;
    eedc_s = eedc_i;
    cmod_s = txcmod_i;
  end

  // Called at posedge+#1. The push is sampled at the next edge n.
  task automatic push(input logic [15:0] w);
    int n;
    int cnt;
    int st;
    int nb;
    int rt;
    bit acc;
    n   = cyc + 1;
    cnt = 0;
    foreach (load_q[i]) if (load_q[i] >= n) cnt++;
    acc = (cnt < 4);
    chk("not_full_before_push", txq_not_full_o, acc);
    txq_we_i  = 1'b1;
    txq_dat_i = w;
    if (acc) begin
      nb = (bits_i == 5'd0) ? 1 : int'(bits_i);
      rt = int'(bitrat_i);
      st = (n + 2 > prev_end) ? n + 2 : prev_end;
      load_q.push_back(st - 1);
      for (int i = 0; i < nb; i++)
        for (int p = 0; p <= rt; p++)
          exp_q.push_back('{st + i * (rt + 1) + p, (i < 16) ? w[i] : 1'b1, p, rt});
      prev_end = st + nb * (rt + 1);
    end
    @(posedge clk_i);
    #1;
    txq_we_i = 1'b0;
  endtask

  task automatic wait_idle(input int exp_edge, input string nm);
    int got;
    got = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk_i);
      if (tx_idle_o) begin
        got = cyc;
        break;
      end
    end
    chk(nm, got, exp_edge);
  endtask

  typedef struct {
    logic [4:0]  bits;
    logic [19:0] rate;
    logic [2:0]  cmod;
    logic [15:0] word;
    int          len;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   n0;

    reset_i   = 1'b0;
    txq_we_i  = 1'b0;
    txq_dat_i = '0;
    bits_i    = 5'd10;
    bitrat_i  = 20'd3;
    txcmod_i  = 3'b000;
    eedd_i    = 1'b1;
    eedc_i    = 1'b1;

    tbl[0] = '{5'd10, 20'd3, 3'b000, 16'h03AA, 40}; // 8N1 frame
    tbl[1] = '{5'd0,  20'd2, 3'b000, 16'h0000, 3};  // bits 0 runs as 1 bit
    tbl[2] = '{5'd20, 20'd0, 3'b100, 16'h5A5A, 20}; // 1-clock bits, clock stays idle, 1s after bit 15
    tbl[3] = '{5'd16, 20'd1, 3'b000, 16'h8001, 32};
    tbl[4] = '{5'd1,  20'd0, 3'b000, 16'h0000, 1};
    tbl[5] = '{5'd5,  20'd4, 3'b100, 16'h0015, 25};

    // Reset defaults
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("rst_txd", txd_o, 1'b1);
    chk("rst_txc", txc_o, 1'b0);
    chk("rst_not_full", txq_not_full_o, 1'b1);
    chk("rst_empty", txq_empty_o, 1'b1);
    chk("rst_idle", tx_idle_o, 1'b1);
    mon_en = 1'b1;

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      bits_i   = tbl[i].bits;
      bitrat_i = tbl[i].rate;
      txcmod_i = tbl[i].cmod;
      n0 = cyc + 1;
      push(tbl[i].word);
      chk("empty_after_push", txq_empty_o, 1'b0);
      wait_idle(n0 + 1 + tbl[i].len, "frame_idle_edge");
      repeat (3) @(posedge clk_i);
      #1;
    end

    // Back-to-back pushes and a full FIFO
    txcmod_i = 3'b000;
    bits_i   = 5'd10;
    bitrat_i = 20'd3;
    n0 = cyc + 1;
    push(16'h03AA);
    push(16'h0355);
    push(16'h030F);
    push(16'h03F0);
    push(16'h0333);
    chk("full_at_4", txq_not_full_o, 1'b0);
    push(16'h0000); // dropped
    wait_idle(n0 + 1 + 5 * 40, "b2b_idle_edge");

    // Clock modes
    @(posedge clk_i);
    #1;
    bits_i   = 5'd3;
    bitrat_i = 20'd7;
    txcmod_i = 3'b100;
    eedc_i   = 1'b1;
    n0 = cyc + 1;
    push(16'h0002);
    wait_idle(n0 + 1 + 24, "clk100_idle_edge");
    @(posedge clk_i);
    #1;
    txcmod_i = 3'b110;
    n0 = cyc + 1;
    push(16'h0005);
    wait_idle(n0 + 1 + 24, "clk110_idle_edge");
    @(posedge clk_i);
    #1;
    eedc_i = 1'b0;
    n0 = cyc + 1;
    push(16'h0002);
    wait_idle(n0 + 1 + 24, "eedc0_idle_edge");
    @(posedge clk_i);
    #1;
    eedc_i   = 1'b1;
    txcmod_i = 3'b000;

    // Mid-frame configuration change
    @(posedge clk_i);
    #1;
    bits_i   = 5'd10;
    bitrat_i = 20'd3;
    n0 = cyc + 1;
    push(16'h02D2);
    repeat (10) @(posedge clk_i);
    #1;
    bits_i   = 5'd5;
    bitrat_i = 20'd1;
    push(16'h0016);
    wait_idle(n0 + 1 + 40 + 10, "cfgchg_idle_edge");

    // Data drive enable dropped mid-frame
    @(posedge clk_i);
    #1;
    bits_i   = 5'd10;
    bitrat_i = 20'd3;
    n0 = cyc + 1;
    push(16'h0100);
    repeat (8) @(posedge clk_i);
    #1;
    eedd_i = 1'b0;
    repeat (12) @(posedge clk_i);
    #1;
    eedd_i = 1'b1;
    wait_idle(n0 + 1 + 40, "eedd_idle_edge");

    // Reset during bit 3 with two words queued
    @(posedge clk_i);
    #1;
    n0 = cyc + 1;
    push(16'h03A0);
    push(16'h0000);
    push(16'h0000);
    repeat (13) @(posedge clk_i);
    #1;
    chk("bit3_before_rst", txd_o, 1'b0);
    mon_en  = 1'b0;
    reset_i = 1'b0;
    exp_q.delete();
    load_q.delete();
    prev_end = 0;
    #1;
    chk("rst_mid_txd", txd_o, 1'b1);
    chk("rst_mid_txc", txc_o, 1'b0);
    chk("rst_mid_empty", txq_empty_o, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    mon_en  = 1'b1;
    repeat (60) @(posedge clk_i);
    #1;
    chk("post_rst_empty", txq_empty_o, 1'b1);
    chk("post_rst_idle", tx_idle_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
